axi_rd_burst_ctrl: RTL

AXI_RD_BURST_CTRL -- requirements
Module: axi_rd_burst_ctrl

---
 rtl/axi_rd_burst_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/axi_rd_burst_ctrl.sv
// rtl/axi_rd_burst_ctrl.sv - AXI read burst engine that streams a linear transfer into an on-chip buffer
module axi_rd_burst_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 256,
    parameter int ID_WIDTH       = 4,
    parameter int LEN_WIDTH      = 8,
    parameter int MAX_BURST      = 256,
    parameter int BEATS_WIDTH    = 20,
    parameter int BUF_ADDR_WIDTH = 19
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [BEATS_WIDTH-1:0]    cmd_beats,
    input  logic [BUF_ADDR_WIDTH-1:0] cmd_buf_addr,
    output logic [ID_WIDTH-1:0]       m_axi_arid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [LEN_WIDTH-1:0]      m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic                      buf_we,
    output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
    output logic [DATA_WIDTH-1:0]     buf_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int SIZE_LOG = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << SIZE_LOG) - ADDR_WIDTH'(1));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]                state;
    logic [ADDR_WIDTH-1:0]     cur_addr;
    logic [BEATS_WIDTH-1:0]    remaining;
    logic [BEATS_WIDTH-1:0]    blen;
    logic [BEATS_WIDTH-1:0]    beat_cnt;
    logic [BUF_ADDR_WIDTH-1:0] wptr;
    logic [LEN_WIDTH-1:0]      ar_len;

    logic [ADDR_WIDTH-1:0]     cmd_aligned;
    logic [ADDR_WIDTH-1:0]     next_addr;
    logic [BEATS_WIDTH-1:0]    next_rem;
    logic [BEATS_WIDTH-1:0]    beat_n;
    logic [BEATS_WIDTH-1:0]    blen_first;
    logic [BEATS_WIDTH-1:0]    blen_next;

    // Burst never crosses a 4 KB page, never exceeds MAX_BURST and never overruns the transfer.
    function automatic logic [BEATS_WIDTH-1:0] calc_blen(
        input logic [ADDR_WIDTH-1:0]  a,
        input logic [BEATS_WIDTH-1:0] rem
    );
        logic [BEATS_WIDTH-1:0] to_page;
        logic [BEATS_WIDTH-1:0] b;
        to_page = BEATS_WIDTH'((13'h1000 - {1'b0, a[11:0]}) >> SIZE_LOG);
        b = rem;
        if (b > BEATS_WIDTH'(MAX_BURST)) b = BEATS_WIDTH'(MAX_BURST);
        if (b > to_page) b = to_page;
        return b;
    endfunction

    assign cmd_aligned = cmd_addr & ALIGN_MASK;
    assign next_addr   = cur_addr + (ADDR_WIDTH'(blen) << SIZE_LOG);
    assign next_rem    = remaining - blen;
    assign beat_n      = beat_cnt + BEATS_WIDTH'(1);
    assign blen_first  = calc_blen(cmd_aligned, cmd_beats);
    assign blen_next   = calc_blen(next_addr, next_rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            blen      <= '0;
            beat_cnt  <= '0;
            wptr      <= '0;
            ar_len    <= '0;
            err       <= 1'b0;
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
        end else begin
            buf_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr  <= cmd_aligned;
                        remaining <= cmd_beats;
                        wptr      <= cmd_buf_addr;
                        err       <= 1'b0;
                        if (cmd_beats == '0) begin
                            state <= S_DONE;
                        end else begin
                            state  <= S_ADDR;
                            blen   <= blen_first;
                            ar_len <= LEN_WIDTH'(blen_first - BEATS_WIDTH'(1));
                        end
                    end
                end
                S_ADDR: begin
                    if (m_axi_arready) begin
                        state    <= S_DATA;
                        beat_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (m_axi_rvalid) begin
                        buf_we    <= 1'b1;
                        buf_addr  <= wptr;
                        buf_wdata <= m_axi_rdata;
                        wptr      <= wptr + BUF_ADDR_WIDTH'(1);
                        beat_cnt  <= beat_n;
                        // rlast must coincide with beat blen; either mismatch direction is an error
                        if (m_axi_rresp != 2'b00 || (m_axi_rlast != (beat_n == blen))) begin
                            err <= 1'b1;
                        end
                        if (m_axi_rlast) begin
                            cur_addr  <= next_addr;
                            remaining <= next_rem;
                            if (next_rem != '0) begin
                                state  <= S_ADDR;
                                blen   <= blen_next;
                                ar_len <= LEN_WIDTH'(blen_next - BEATS_WIDTH'(1));
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign m_axi_arvalid = (state == S_ADDR);
    assign m_axi_rready  = (state == S_DATA);
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = cur_addr;
    assign m_axi_arlen   = ar_len;
    assign m_axi_arsize  = 3'(SIZE_LOG);
    assign m_axi_arburst = 2'b01;
endmodule
